// File: rtl/imem_load_pkg.sv
// Shared types and constants for the pad-driven instruction-memory loader.
package imem_load_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2
  } load_state_e;

  localparam int IMEM_ADDR_W = 10;
  localparam int IMEM_DATA_W = 40;
  localparam int PAD_BUS_W   = 8;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/pad_sync.sv
// Multi-stage synchroniser for asynchronous pad inputs, cleared by the async reset.
module pad_sync #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_chain [SYNC_STAGES];

  // Flop chain; only the last stage is safe to use in the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_chain[i] <= {WIDTH{1'b0}};
      end
    end else begin
      r_chain[0] <= i_d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_chain[i] <= r_chain[i-1];
      end
    end
  end

  assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/imem_stream_loader.sv
// Assembles imem write transactions from a strobed pad bus, with optional
// data-only streaming against an internal auto-incrementing address.
module imem_stream_loader
  import imem_load_pkg::*;
#(
  parameter int IN_W        = PAD_BUS_W,
  parameter int ADDR_W      = IMEM_ADDR_W,
  parameter int DATA_W      = IMEM_DATA_W,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic              auto_inc,
  input  logic              strobe,
  input  logic [IN_W-1:0]   din,
  output logic [ADDR_W-1:0] imem_write_adr,
  output logic [DATA_W-1:0] imem_in,
  output logic              imem_write,
  output logic              busy,
  output logic [CNT_W-1:0]  word_count,
  output logic              err_partial
);

  localparam int NF   = ceil_div(ADDR_W + DATA_W, IN_W);
  localparam int ND   = ceil_div(DATA_W, IN_W);
  localparam int SH_W = ADDR_W + DATA_W;
  localparam int CC_W = $clog2(NF + 1);
  localparam logic [CC_W-1:0] LAST_F = CC_W'(NF - 1);
  localparam logic [CC_W-1:0] LAST_D = CC_W'(ND - 1);

  logic              w_load_en_s;
  logic              w_strobe_s;
  logic [IN_W-1:0]   w_din_s;
  logic              w_le_rise;
  logic              w_le_fall;
  logic              w_chk;
  logic [CC_W-1:0]   w_chunk_base;
  logic [CC_W-1:0]   w_cnt_inc;
  logic              w_last;
  logic [SH_W-1:0]   w_shift_next;

  load_state_e       r_state;
  logic              r_mode;
  logic              r_load_en_d;
  logic              r_strobe_d;
  logic [CC_W-1:0]   r_chunk_cnt;
  logic [SH_W-1:0]   r_shift;
  logic [ADDR_W-1:0] r_addr_cnt;
  logic [ADDR_W-1:0] r_adr;
  logic [DATA_W-1:0] r_imem_in;
  logic              r_imem_write;
  logic              r_busy;
  logic [CNT_W-1:0]  r_word_count;
  logic              r_err;

  pad_sync #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES)) u_sync_load_en (
    .clk(clk), .rst_n(reset), .i_d(load_en), .o_q(w_load_en_s)
  );

  pad_sync #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES)) u_sync_strobe (
    .clk(clk), .rst_n(reset), .i_d(strobe), .o_q(w_strobe_s)
  );

  // din shares the strobe's depth so the chunk is aligned with its edge.
  pad_sync #(.WIDTH(IN_W), .SYNC_STAGES(SYNC_STAGES)) u_sync_din (
    .clk(clk), .rst_n(reset), .i_d(din), .o_q(w_din_s)
  );

  assign w_le_rise    = w_load_en_s & ~r_load_en_d;
  assign w_le_fall    = ~w_load_en_s & r_load_en_d;
  assign w_chk        = w_strobe_s & ~r_strobe_d;
  // A chunk accepted in WRITE is chunk 0 of the next word.
  assign w_chunk_base = (r_state == WRITE) ? {CC_W{1'b0}} : r_chunk_cnt;
  assign w_cnt_inc    = w_chunk_base + CC_W'(1);
  assign w_last       = (w_chunk_base == (r_mode ? LAST_D : LAST_F));
  assign w_shift_next = SH_W'({r_shift, w_din_s});

  // Loader FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_mode       <= 1'b0;
      r_load_en_d  <= 1'b0;
      r_strobe_d   <= 1'b0;
      r_chunk_cnt  <= {CC_W{1'b0}};
      r_shift      <= {SH_W{1'b0}};
      r_addr_cnt   <= {ADDR_W{1'b0}};
      r_adr        <= {ADDR_W{1'b0}};
      r_imem_in    <= {DATA_W{1'b0}};
      r_imem_write <= 1'b0;
      r_busy       <= 1'b0;
      r_word_count <= {CNT_W{1'b0}};
      r_err        <= 1'b0;
    end else begin
      r_load_en_d  <= w_load_en_s;
      r_strobe_d   <= w_strobe_s;
      r_imem_write <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_le_rise) begin
            r_mode       <= auto_inc;
            r_addr_cnt   <= {ADDR_W{1'b0}};
            r_chunk_cnt  <= {CC_W{1'b0}};
            r_busy       <= 1'b0;
            r_word_count <= {CNT_W{1'b0}};
            r_err        <= 1'b0;
            r_shift      <= {SH_W{1'b0}};
            r_state      <= COLLECT;
          end
        end
        COLLECT: begin
          if (w_le_fall) begin
            if (r_chunk_cnt != {CC_W{1'b0}}) begin
              r_err <= 1'b1;
            end
            r_chunk_cnt <= {CC_W{1'b0}};
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end else if (w_chk) begin
            r_shift     <= w_shift_next;
            r_chunk_cnt <= w_cnt_inc;
            r_busy      <= 1'b1;
            if (w_last) begin
              r_state <= WRITE;
            end
          end
        end
        WRITE: begin
          r_imem_write <= 1'b1;
          r_imem_in    <= r_shift[DATA_W-1:0];
          r_adr        <= r_mode ? r_addr_cnt : r_shift[SH_W-1:DATA_W];
          if (r_word_count != {CNT_W{1'b1}}) begin
            r_word_count <= r_word_count + CNT_W'(1);
          end
          if (r_mode) begin
            r_addr_cnt <= r_addr_cnt + ADDR_W'(1);
          end
          if (w_le_fall) begin
            r_chunk_cnt <= {CC_W{1'b0}};
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end else if (w_chk) begin
            r_shift     <= w_shift_next;
            r_chunk_cnt <= w_cnt_inc;
            r_busy      <= 1'b1;
            r_state     <= w_last ? WRITE : COLLECT;
          end else begin
            r_chunk_cnt <= {CC_W{1'b0}};
            r_busy      <= 1'b0;
            r_state     <= COLLECT;
          end
        end
        default: begin
          r_chunk_cnt <= {CC_W{1'b0}};
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign imem_write_adr = r_adr;
  assign imem_in        = r_imem_in;
  assign imem_write     = r_imem_write;
  assign busy           = r_busy;
  assign word_count     = r_word_count;
  assign err_partial    = r_err;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Scoreboard bench: three loader configurations sharing clock, reset and strobe bus.
module tb_imem_stream_loader;

  localparam int SS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       le_a, le_b, le_c;
  logic       auto_inc;
  logic       strobe;
  logic [7:0] din;

  logic [9:0]  adr_a;  logic [39:0] data_a; logic wr_a, busy_a, err_a; logic [15:0] wc_a;
  logic [1:0]  adr_b;  logic [39:0] data_b; logic wr_b, busy_b, err_b; logic [15:0] wc_b;
  logic [5:0]  adr_c;  logic [9:0]  data_c; logic wr_c, busy_c, err_c; logic [15:0] wc_c;

  imem_stream_loader #(.IN_W(8), .ADDR_W(10), .DATA_W(40), .SYNC_STAGES(SS), .CNT_W(16)) u_dut_a (
    .clk(clk), .reset(reset), .load_en(le_a), .auto_inc(auto_inc), .strobe(strobe), .din(din),
    .imem_write_adr(adr_a), .imem_in(data_a), .imem_write(wr_a), .busy(busy_a),
    .word_count(wc_a), .err_partial(err_a)
  );

  imem_stream_loader #(.IN_W(8), .ADDR_W(2), .DATA_W(40), .SYNC_STAGES(SS), .CNT_W(16)) u_dut_b (
    .clk(clk), .reset(reset), .load_en(le_b), .auto_inc(auto_inc), .strobe(strobe), .din(din),
    .imem_write_adr(adr_b), .imem_in(data_b), .imem_write(wr_b), .busy(busy_b),
    .word_count(wc_b), .err_partial(err_b)
  );

  imem_stream_loader #(.IN_W(4), .ADDR_W(6), .DATA_W(10), .SYNC_STAGES(SS), .CNT_W(16)) u_dut_c (
    .clk(clk), .reset(reset), .load_en(le_c), .auto_inc(auto_inc), .strobe(strobe), .din(din[3:0]),
    .imem_write_adr(adr_c), .imem_in(data_c), .imem_write(wr_c), .busy(busy_c),
    .word_count(wc_c), .err_partial(err_c)
  );

  typedef struct {
    logic [15:0] adr;
    logic [63:0] data;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  int   wr_cnt_a = 0;
  int   wr_cnt_b = 0;
  int   wr_cnt_c = 0;
  int   checks   = 0;
  int   failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Write monitors: pop the oldest expected word for each observed pulse.
  always @(negedge clk) begin
    exp_t e;
    if (wr_a === 1'b1) begin
      wr_cnt_a++;
      if (q_a.size() == 0) begin
        check_eq("a_unexpected_wr", 64'(wr_a), 64'd0);
      end else begin
        e = q_a.pop_front();
        check_eq("a_adr", 64'(adr_a), 64'(e.adr));
        check_eq("a_data", 64'(data_a), e.data);
      end
    end
    if (wr_b === 1'b1) begin
      wr_cnt_b++;
      if (q_b.size() == 0) begin
        check_eq("b_unexpected_wr", 64'(wr_b), 64'd0);
      end else begin
        e = q_b.pop_front();
        check_eq("b_adr", 64'(adr_b), 64'(e.adr));
        check_eq("b_data", 64'(data_b), e.data);
      end
    end
    if (wr_c === 1'b1) begin
      wr_cnt_c++;
      if (q_c.size() == 0) begin
        check_eq("c_unexpected_wr", 64'(wr_c), 64'd0);
      end else begin
        e = q_c.pop_front();
        check_eq("c_adr", 64'(adr_c), 64'(e.adr));
        check_eq("c_data", 64'(data_c), e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_chunk(input logic [7:0] d, input int period);
    din    = d;
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    repeat (period - 1) tick();
  endtask

  logic [7:0] m0 [7] = '{8'h00, 8'h02, 8'hAB, 8'hCD, 8'hEF, 8'h12, 8'h34};
  logic [7:0] w1 [7] = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
  logic [7:0] w2 [7] = '{8'h03, 8'hFF, 8'h99, 8'h88, 8'h77, 8'h66, 8'hAA};
  logic [7:0] mc [4] = '{8'hAF, 8'h52, 8'hCA, 8'h3B};

  initial begin
    int n;
    int lat;
    logic [39:0] bdata;
    reset = 1'b0; le_a = 1'b0; le_b = 1'b0; le_c = 1'b0;
    auto_inc = 1'b0; strobe = 1'b0; din = 8'h00;
    repeat (3) tick();
    check_eq("rst_adr", 64'(adr_a), 64'd0);
    check_eq("rst_data", 64'(data_a), 64'd0);
    check_eq("rst_wr_busy_err", 64'({wr_a, busy_a, err_a}), 64'd0);
    check_eq("rst_wc", 64'(wc_a), 64'd0);
    reset = 1'b1;
    repeat (3) tick();

    // Mode 0 single word with write-pulse latency measurement.
    le_a = 1'b1;
    repeat (5) tick();
    q_a.push_back('{16'h002, 64'hAB_CDEF_1234});
    for (int i = 0; i < 6; i++) send_chunk(m0[i], 4);
    din = m0[6]; strobe = 1'b1; lat = 0;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      tick();
      if (i == 1) strobe = 1'b0;
      if (wr_a === 1'b1) lat = i;
    end
    check_eq("a_latency", 64'(lat), 64'(SS + 2));
    repeat (4) tick();
    check_eq("a_wc_one", 64'(wc_a), 64'd1);
    check_eq("a_busy_after", 64'(busy_a), 64'd0);

    // Partial abort.
    le_a = 1'b0; repeat (5) tick();
    le_a = 1'b1; repeat (5) tick();
    check_eq("a_wc_cleared", 64'(wc_a), 64'd0);
    for (int i = 0; i < 3; i++) send_chunk(m0[i], 4);
    check_eq("a_busy_partial", 64'(busy_a), 64'd1);
    n = wr_cnt_a;
    le_a = 1'b0; repeat (6) tick();
    check_eq("a_err_set", 64'(err_a), 64'd1);
    check_eq("a_busy_abort", 64'(busy_a), 64'd0);
    check_eq("a_no_wr_abort", 64'(wr_cnt_a), 64'(n));
    le_a = 1'b1; repeat (5) tick();
    check_eq("a_err_cleared", 64'(err_a), 64'd0);
    check_eq("a_wc_rise", 64'(wc_a), 64'd0);

    // Back-to-back words at the minimum strobe spacing.
    q_a.push_back('{16'h001, 64'h11_2233_4455});
    q_a.push_back('{16'h3FF, 64'h99_8877_66AA});
    for (int i = 0; i < 7; i++) send_chunk(w1[i], SS + 1);
    for (int i = 0; i < 7; i++) send_chunk(w2[i], SS + 1);
    repeat (6) tick();
    check_eq("a_wc_b2b", 64'(wc_a), 64'd2);

    // Async reset mid-word.
    for (int i = 0; i < 4; i++) send_chunk(w1[i], 4);
    #3;
    reset = 1'b0;
    le_a  = 1'b0;
    #1;
    check_eq("mid_rst_adr", 64'(adr_a), 64'd0);
    check_eq("mid_rst_data", 64'(data_a), 64'd0);
    check_eq("mid_rst_wr_busy_err", 64'({wr_a, busy_a, err_a}), 64'd0);
    check_eq("mid_rst_wc", 64'(wc_a), 64'd0);
    repeat (3) tick();
    reset = 1'b1;
    repeat (3) tick();
    n = wr_cnt_a;
    for (int i = 0; i < 7; i++) send_chunk(m0[i], 4);
    repeat (4) tick();
    check_eq("a_idle_ignore_wr", 64'(wr_cnt_a), 64'(n));
    check_eq("a_idle_ignore_busy", 64'(busy_a), 64'd0);
    le_a = 1'b1; repeat (5) tick();
    q_a.push_back('{16'h002, 64'hAB_CDEF_1234});
    for (int i = 0; i < 7; i++) send_chunk(m0[i], 4);
    repeat (5) tick();
    check_eq("a_wc_post_rst", 64'(wc_a), 64'd1);
    le_a = 1'b0; repeat (5) tick();

    // Narrow configuration: upper address bits above 16 discarded.
    le_c = 1'b1; auto_inc = 1'b0; repeat (5) tick();
    q_c.push_back('{16'h03C, 64'h2AB});
    for (int i = 0; i < 4; i++) send_chunk(mc[i], 4);
    repeat (5) tick();
    check_eq("c_wc", 64'(wc_c), 64'd1);
    le_c = 1'b0; repeat (5) tick();

    // Auto-increment with a 2-bit address wrapping after four words.
    le_b = 1'b1; auto_inc = 1'b1; repeat (5) tick();
    auto_inc = 1'b0;
    for (int w = 0; w < 5; w++) begin
      bdata = {8'(8'h10 + w), 8'(8'h20 + w), 8'(8'h30 + w), 8'(8'h40 + w), 8'(8'h50 + w)};
      q_b.push_back('{16'(w % 4), 64'(bdata)});
      for (int k = 0; k < 5; k++) send_chunk(bdata[39 - 8*k -: 8], 4);
    end
    repeat (5) tick();
    check_eq("b_wc", 64'(wc_b), 64'd5);
    check_eq("b_busy", 64'(busy_b), 64'd0);
    le_b = 1'b0; repeat (5) tick();

    check_eq("a_sb_empty", 64'(q_a.size()), 64'd0);
    check_eq("b_sb_empty", 64'(q_b.size()), 64'd0);
    check_eq("c_sb_empty", 64'(q_c.size()), 64'd0);
    check_eq("a_wr_total", 64'(wr_cnt_a), 64'd4);
    check_eq("b_wr_total", 64'(wr_cnt_b), 64'd5);
    check_eq("c_wr_total", 64'(wr_cnt_c), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
- Parametrised successor to the pad-level instruction-memory write path.
- Assembles instruction-memory write transactions from a narrow, externally strobed pad bus into address/data words.
- The strobe and data bus come from asynchronous pads. Both are synchronised into clk, so no pad signal is used as a clock.
- Adds an auto-increment mode (data-only streaming), a one-cycle write pulse, a word counter and a sticky partial-word error.
- Sits between the pad ring and the core's imem write port.

Parameters:
IN_W, 8, pad data bus width per strobe (chunk)
ADDR_W, 10, imem address width
DATA_W, 40, imem word width
SYNC_STAGES, 2, synchroniser depth for strobe, load_en and din (minimum 2)
CNT_W, 16, width of the written-word counter

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset
load_en  in  1  pad: loader enable (async)
auto_inc  in  1  pad: 1 = data-only chunks with internal address counter; 0 = address+data chunks (async, sampled only on load_en rise)
strobe  in  1  pad: chunk strobe, rising edge = chunk valid (async)
din  in  IN_W  pad chunk data, stable around strobe rise
imem_write_adr  out  ADDR_W  registered write address
imem_in  out  DATA_W  registered write data
imem_write  out  1  one-cycle write pulse
busy  out  1  a word is partially assembled
word_count  out  CNT_W  words written since last load_en rise, saturating
err_partial  out  1  sticky: load_en fell mid-word

Behaviour:
- Reset (reset=0, async): all outputs 0, state IDLE, shift register 0, address counter 0, synchronisers 0.
- Sync
  - load_en, strobe and din each pass through a SYNC_STAGES flop chain.
  - An edge detect on synchronised strobe gives chk (one cycle per rising edge).
  - din is taken from the same stage as the strobe, so they stay aligned.
- Chunk counts
  - NF = ceil((ADDR_W+DATA_W)/IN_W); default 7 (56 bits, 50 used).
  - ND = ceil(DATA_W/IN_W); default 5.
  - Chunks arrive MSB first; the word is right-aligned in the shift register. Unused top bits are discarded.
- FSM states: IDLE, COLLECT, WRITE.
  - IDLE: on synchronised load_en rise:
    - latch mode = auto_inc;
    - clear address counter, chunk counter, word_count and err_partial;
    - go to COLLECT.
  - COLLECT: on chk, shift left by IN_W inserting din and increment the chunk counter. busy=1 while the chunk counter is non-zero. On the last chunk (NF or ND per mode), go to WRITE.
  - WRITE (exactly one cycle):
    - imem_write=1;
    - register imem_in = shift[DATA_W-1:0];
    - register imem_write_adr = shift[ADDR_W+DATA_W-1:DATA_W] (mode 0) or the address counter (mode 1);
    - clear the chunk counter;
    - increment word_count (saturate at all-ones);
    - in mode 1, increment the address counter, wrapping 2^ADDR_W-1 -> 0;
    - return to COLLECT.
  - A chk arriving during WRITE is accepted as chunk 0 of the next word. With SYNC_STAGES>=2 strobes cannot occur on consecutive cycles, so none is lost.
- Outputs imem_write_adr/imem_in hold their last value between writes.
- Latency
  - strobe pin rise -> chk: SYNC_STAGES+1 clocks.
  - Final chk -> imem_write high: next clock.
- load_en fall (synchronised), from COLLECT or WRITE:
  - if WRITE, the write completes this cycle;
  - then go to IDLE and discard the partial word;
  - if the chunk counter was non-zero (and not in WRITE), set err_partial=1.
  - err_partial stays set until the next load_en rise or reset.
- chk in IDLE is ignored.
- Mode changes while not IDLE are ignored.
- Reset mid-word: immediate return to reset state; no write is issued.

Decomposition:
- Shared package imem_load_pkg holds:
  - state enum (IDLE, COLLECT, WRITE);
  - function ceil_div;
  - default width constants IMEM_ADDR_W=10, IMEM_DATA_W=40, PAD_BUS_W=8.
- One sub-module, pad_sync (width parameter, SYNC_STAGES flop chain, async active-low clear). It is instantiated for load_en, strobe and din; the edge detect stays in the top level.

Test Plan:
- Mode 0, defaults:
  - load_en=1, auto_inc=0, 7 strobes with din 00,02,AB,CD,EF,12,34;
  - expect one imem_write pulse with imem_write_adr=0x002 and imem_in=0xABCDEF1234;
  - expect pulse SYNC_STAGES+2 clocks after the 7th strobe rise; word_count=1; busy=0 after.
- Mode 1 wrap, ADDR_W=2:
  - auto_inc=1, 5 words of 5 chunks;
  - expect addresses 0,1,2,3,0 in order; data matches chunks; word_count=5.
- Partial abort:
  - mode 0, 3 strobes then load_en=0;
  - expect no imem_write, err_partial=1, busy=0;
  - next load_en rise clears err_partial and word_count.
- Back-to-back:
  - strobes spaced SYNC_STAGES+1 clocks, last chunk of word N immediately followed by the first chunk of word N+1;
  - expect both words written correctly; no chunk lost.
- Async reset mid-word:
  - drive reset=0 after 4 chunks;
  - expect all outputs 0 immediately; no write pulse;
  - after release, strobes are ignored until a load_en rise.
- Parametric IN_W=4, DATA_W=10, ADDR_W=6:
  - mode 0, NF=4 chunks F,2,A,B;
  - expect imem_write_adr=0x3C and imem_in=0x2AB (MSB discard check).
